// File: rtl/sdpram_rd_streamer.sv
// Burst read master for the port-B side of a simple dual-port RAM.
// Issues up to three outstanding reads and returns data as a valid/ready stream.
module sdpram_rd_streamer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int MEM_DEPTH  = 1024,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  renb_o,
   output logic [ADDR_WIDTH-1:0] addrb_o,
   input  logic [DATA_WIDTH-1:0] doutb_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_last_o
);

   if (MEM_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("MEM_DEPTH must be a power of 2");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   addrb_q;
   logic [ADDR_WIDTH:0]     issue_cnt_q;
   logic                    renb_q;
   logic                    renb_last_q;
   logic                    inflight_q;
   logic                    inflight_last_q;
   logic                    done_q;

   logic [1:0]              wr_ptr_q;
   logic [1:0]              rd_ptr_q;
   logic [1:0]              count_q;
   logic [1:0]              count_d;
   logic [DATA_WIDTH-1:0]   fifo_data [0:2];
   logic [2:0]              fifo_last;

   logic                    push;
   logic                    pop;
   logic                    room;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign push = inflight_q;
   assign pop  = (count_q != 2'd0) && m_ready_i;

   // Room is judged on next-cycle occupancy plus reads already on the wire,
   // so a word is only requested when its FIFO slot is guaranteed.
   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      room    = ({1'b0, count_d} + {2'b00, renb_q}) < 3'd3;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         addrb_q     <= '0;
         issue_cnt_q <= '0;
         renb_q      <= 1'b0;
         renb_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         renb_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (len_i != '0) begin
                     renb_q      <= 1'b1;
                     addrb_q     <= start_addr_i;
                     addr_q      <= next_addr(start_addr_i);
                     issue_cnt_q <= len_i - 1'b1;
                     renb_last_q <= (len_i == (ADDR_WIDTH+1)'(1));
                     state_q     <= (len_i == (ADDR_WIDTH+1)'(1)) ? DRAIN : RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (room) begin
                  renb_q      <= 1'b1;
                  addrb_q     <= addr_q;
                  addr_q      <= next_addr(addr_q);
                  issue_cnt_q <= issue_cnt_q - 1'b1;
                  renb_last_q <= (issue_cnt_q == (ADDR_WIDTH+1)'(1));
                  if (issue_cnt_q == (ADDR_WIDTH+1)'(1)) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last_o) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         inflight_q      <= renb_q;
         inflight_last_q <= renb_q & renb_last_q;
         count_q         <= count_d;
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_q;
      logic                  last_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            data_q <= '0;
            last_q <= 1'b0;
         end else if (push && (wr_ptr_q == 2'(gi))) begin
            data_q <= doutb_i;
            last_q <= inflight_last_q;
         end
      end

      assign fifo_data[gi] = data_q;
      assign fifo_last[gi] = last_q;
   end

   assign busy_o    = (state_q != IDLE);
   assign done_o    = done_q;
   assign renb_o    = renb_q;
   assign addrb_o   = addrb_q;
   assign m_valid_o = (count_q != 2'd0);
   assign m_data_o  = fifo_data[rd_ptr_q];
   assign m_last_o  = fifo_last[rd_ptr_q] && (count_q != 2'd0);

endmodule

// File: tb/tb_sdpram_rd_streamer.sv
// Bench for sdpram_rd_streamer: RAM model plus an address/beat scoreboard
// filled from the burst rules (start address, length, wrap at MEM_DEPTH).
module tb_sdpram_rd_streamer;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          renb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   logic [DW-1:0] mem [DEPTH];

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int renb_cnt = 0;
   int busy_cnt = 0;

   int            exp_addr_q [$];
   logic [DW-1:0] exp_data_q [$];
   logic          exp_last_q [$];

   sdpram_rd_streamer #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_addr_i (start_addr),
      .len_i        (len),
      .busy_o       (busy),
      .done_o       (done),
      .renb_o       (renb),
      .addrb_o      (addrb),
      .doutb_i      (doutb),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data),
      .m_last_o     (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (renb) doutb <= mem[addrb];
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string p);
      check_val({p, "_renb"},    64'(renb),    0);
      check_val({p, "_addrb"},   64'(addrb),   0);
      check_val({p, "_m_valid"}, 64'(m_valid), 0);
      check_val({p, "_m_data"},  64'(m_data),  0);
      check_val({p, "_m_last"},  64'(m_last),  0);
      check_val({p, "_busy"},    64'(busy),    0);
      check_val({p, "_done"},    64'(done),    0);
   endtask

   // Expected reads and beats follow directly from (start, len) with wrap.
   task automatic drive_start(input int sa, input int ln);
      for (int i = 0; i < ln; i++) begin
         int a;
         a = (sa + i) % DEPTH;
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem[a]);
         exp_last_q.push_back(i == ln - 1);
      end
      start      = 1'b1;
      start_addr = AW'(sa);
      len        = (AW+1)'(ln);
   endtask

   // mode 0: always ready, 1: random ready, 2: stall 6 cycles then toggle
   task automatic wait_done(input int ln, input int mode, input bit poke,
                            input bit chain, input int nsa, input int nln);
      int cyc     = 0;
      int first_v = -1;
      int done_c  = -1;
      while (done_c < 0 && cyc < 4 * ln + 60) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = (cyc < 6) ? 1'b0 : (cyc < 10) ? ((cyc % 2) == 0) : 1'b1;
         endcase
         start = 1'b0;
         if (poke && cyc == 3) begin
            start      = 1'b1;
            start_addr = AW'(12'h155);
            len        = (AW+1)'(7);
         end
         @(negedge clk);
         if (first_v < 0 && m_valid) first_v = cyc;
         if (done) done_c = cyc;
         if (done_c < 0) begin
            cyc++;
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      check_val("done_seen",  64'(done_c >= 0), 1);
      check_val("beats_left", 64'(exp_data_q.size()), 0);
      check_val("reads_left", 64'(exp_addr_q.size()), 0);
      if (mode == 0) begin
         check_val("done_cycle", 64'(done_c), 64'((ln == 0) ? 0 : ln + 2));
         if (ln > 0) check_val("first_valid", 64'(first_v), 2);
      end
      $display("burst len=%0d mode=%0d done_cycle=%0d", ln, mode, done_c);
      if (chain) begin
         drive_start(nsa, nln);
         @(posedge clk);
         #1;
         start = 1'b0;
         check_val("chain_renb", 64'(renb), 1);
      end else begin
         @(negedge clk);
         check_val("done_pulse", 64'(done), 0);
      end
   endtask

   initial begin : monitor
      bit            stall_prev = 1'b0;
      logic [DW-1:0] prev_data  = '0;
      logic          prev_last  = 1'b0;
      int            pending    = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
            pending    = 0;
         end else begin
            if (renb) begin
               if (exp_addr_q.size() == 0) check_val("extra_read", 1, 0);
               else check_val("addrb", 64'(addrb), 64'(exp_addr_q.pop_front()));
               pending++;
               check_val("pending_le3", 64'(pending <= 3), 1);
               renb_cnt++;
            end
            if (busy) busy_cnt++;
            if (stall_prev) begin
               check_val("hold_valid", 64'(m_valid), 1);
               check_val("hold_data",  64'(m_data),  64'(prev_data));
               check_val("hold_last",  64'(m_last),  64'(prev_last));
            end
            if (m_valid && m_ready) begin
               hs_cnt++;
               pending--;
               if (exp_data_q.size() == 0) check_val("extra_beat", 1, 0);
               else begin
                  check_val("m_data", 64'(m_data), 64'(exp_data_q.pop_front()));
                  check_val("m_last", 64'(m_last), 64'(exp_last_q.pop_front()));
               end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   initial begin : stimulus
      int r0, b0, h0, cyc;
      rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA000_0000 + 32'(i);
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      drive_start(16'h10, 4);
      @(posedge clk); #1; start = 1'b0;
      wait_done(4, 0, 1'b0, 1'b0, 0, 0);

      drive_start(16'h3FE, 4);
      @(posedge clk); #1; start = 1'b0;
      wait_done(4, 0, 1'b0, 1'b0, 0, 0);

      drive_start(16'h40, 16);
      @(posedge clk); #1; start = 1'b0;
      wait_done(16, 2, 1'b0, 1'b0, 0, 0);

      r0 = renb_cnt; b0 = busy_cnt;
      drive_start(5, 0);
      @(posedge clk); #1; start = 1'b0;
      wait_done(0, 0, 1'b0, 1'b0, 0, 0);
      check_val("len0_renb", 64'(renb_cnt - r0), 0);
      check_val("len0_busy", 64'(busy_cnt - b0), 0);

      drive_start(16'h80, 10);
      @(posedge clk); #1; start = 1'b0;
      wait_done(10, 1, 1'b1, 1'b0, 0, 0);

      drive_start(16'h90, 5);
      @(posedge clk); #1; start = 1'b0;
      wait_done(5, 0, 1'b0, 1'b1, 16'hA0, 3);
      wait_done(3, 0, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 6; k++) begin
         int sa, ln;
         sa = $urandom_range(0, DEPTH - 1);
         ln = $urandom_range(1, 40);
         drive_start(sa, ln);
         @(posedge clk); #1; start = 1'b0;
         wait_done(ln, 1, 1'b0, 1'b0, 0, 0);
      end

      drive_start(16'h3F0, 1100);
      @(posedge clk); #1; start = 1'b0;
      wait_done(1100, 0, 1'b0, 1'b0, 0, 0);

      drive_start(16'h30, 8);
      @(posedge clk); #1; start = 1'b0; m_ready = 1'b1;
      h0 = hs_cnt; cyc = 0;
      while (hs_cnt < h0 + 2 && cyc < 50) begin
         @(posedge clk);
         cyc++;
      end
      check_val("hs_wait", 64'(hs_cnt - h0), 2);
      #1 rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_last_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive_start(16'h20, 2);
      @(posedge clk); #1; start = 1'b0;
      wait_done(2, 0, 1'b0, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
